// File: rtl/audio_frame_scheduler.sv
// Ping-pong frame buffer between the DSP synthesis chain and the UART byte transmitter.
// One bank fills with sample top-bytes while the other streams out as SYNC + BUF_LEN bytes.
module audio_frame_scheduler #(
  parameter int         BITS      = 16,
  parameter int         BUF_LEN   = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            sample_strobe,
  input  logic [BITS-1:0] sample_in,
  output logic            dsp_en,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [7:0]      frame_count,
  output logic [7:0]      overrun_count,
  output logic            busy
);

  localparam int               IDX_W    = $clog2(BUF_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_LEN - 1);

  typedef enum logic {F_IDLE, F_FILL} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_SYNC, D_DATA} drain_state_t;

  function automatic logic [7:0] capture_byte(input logic signed [BITS-1:0] s);
    return 8'(s >>> (BITS - 8));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fill_state_t      f_state_q, f_state_d;
  drain_state_t     d_state_q, d_state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic [7:0]       overrun_count_q, overrun_count_d;

  logic [7:0]       mem_q [2][BUF_LEN];

  logic signed [BITS-1:0] sample_s;
  logic                   fill_accept;
  logic                   fill_write;
  logic                   fill_done;
  logic                   overrun_hit;
  logic                   tx_fire;
  logic                   drain_done;

  assign sample_s = sample_in;

  // ---- fill side: event decode ----
  always_comb begin
    fill_accept = (f_state_q == F_IDLE) && frame_tick && !full_q[wr_bank_q];
    fill_write  = (f_state_q == F_FILL) && sample_strobe;
    fill_done   = fill_write && (wr_idx_q == LAST_IDX);
    overrun_hit = frame_tick && ((f_state_q == F_FILL) || full_q[wr_bank_q]);
  end

  always_comb begin
    f_state_d = f_state_q;
    case (f_state_q)
      F_IDLE:  if (fill_accept) f_state_d = F_FILL;
      F_FILL:  if (fill_done)   f_state_d = F_IDLE;
      default: f_state_d = F_IDLE;
    endcase
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (fill_accept) begin
      wr_idx_d = '0;
    end else if (fill_done) begin
      wr_idx_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (fill_write) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end
  end

  // ---- drain side: event decode and next state ----
  always_comb begin
    tx_fire    = tx_valid && tx_ready;
    drain_done = (d_state_q == D_DATA) && tx_fire && (rd_idx_q == LAST_IDX);
  end

  always_comb begin
    d_state_d = d_state_q;
    case (d_state_q)
      D_IDLE:  if (full_q[rd_bank_q]) d_state_d = D_SYNC;
      D_SYNC:  if (tx_fire)           d_state_d = D_DATA;
      D_DATA:  if (drain_done)        d_state_d = D_IDLE;
      default: d_state_d = D_IDLE;
    endcase
  end

  always_comb begin
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    if ((d_state_q == D_SYNC) && tx_fire) begin
      rd_idx_d = '0;
    end else if (drain_done) begin
      rd_idx_d  = '0;
      rd_bank_d = ~rd_bank_q;
    end else if ((d_state_q == D_DATA) && tx_fire) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
  end

  // The filling and draining banks always differ, so both full-bit updates may land together.
  always_comb begin
    full_d = full_q;
    if (fill_done)  full_d[wr_bank_q] = 1'b1;
    if (drain_done) full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    frame_count_d   = frame_count_q;
    overrun_count_d = overrun_count_q;
    if (drain_done)  frame_count_d   = frame_count_q + 8'd1;
    if (overrun_hit) overrun_count_d = sat_inc8(overrun_count_q);
  end

  // ---- output decode ----
  always_comb begin
    tx_valid = (d_state_q != D_IDLE);
    case (d_state_q)
      D_SYNC:  tx_data = SYNC_BYTE;
      D_DATA:  tx_data = mem_q[rd_bank_q][rd_idx_q];
      default: tx_data = 8'h00;
    endcase
    dsp_en        = (f_state_q == F_FILL);
    busy          = (f_state_q == F_FILL) || (d_state_q != D_IDLE) || (|full_q);
    frame_count   = frame_count_q;
    overrun_count = overrun_count_q;
  end

  // ---- control registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state_q       <= F_IDLE;
      d_state_q       <= D_IDLE;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      full_q          <= 2'b00;
      frame_count_q   <= 8'd0;
      overrun_count_q <= 8'd0;
    end else begin
      f_state_q       <= f_state_d;
      d_state_q       <= d_state_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      full_q          <= full_d;
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  // ---- sample storage (no reset; stale bytes are never read before being rewritten) ----
  always_ff @(posedge clk) begin
    if (fill_write) mem_q[wr_bank_q][wr_idx_q] <= capture_byte(sample_s);
  end

endmodule
